// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants, arbitration slot encoding and the constant-multiply helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned CNT_W        = 10;

  // What the VRAM port does in the next registered cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2,
    SLOT_DROP  = 2'd3
  } slot_e;

  // y * k as a sum of shifted copies of y; k is a constant, so only its set bits cost adders.
  function automatic logic [ADDR_W-1:0] mul_const(input logic [CNT_W-1:0] y,
                                                  input int unsigned     k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (k[b]) acc = acc + (ADDR_W'(y) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// VRAM address register: display address y*H_ACTIVE+x (shift-add) for reads, draw address for writes.
module vram_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  slot_e             i_slot,
  input  logic              i_disp_sel,
  input  logic              i_draw_sel,
  input  logic [CNT_W-1:0]  i_hcount,
  input  logic [CNT_W-1:0]  i_vcount,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic [ADDR_W:0]   o_ram_addr
);

  logic [ADDR_W-1:0] w_disp_addr;

  assign w_disp_addr = mul_const(i_vcount, H_ACTIVE) + ADDR_W'(i_hcount);

  // Address holds when the port is idle or a write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ram_addr <= '0;
    end else begin
      case (i_slot)
        SLOT_READ:  o_ram_addr <= {i_disp_sel, w_disp_addr};
        SLOT_WRITE: o_ram_addr <= {i_draw_sel, i_wr_addr};
        default:    o_ram_addr <= o_ram_addr;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win over drawing writes; pixel pipeline to the DAC.
// Optional frame-buffer swapping is enabled by defining VRAM_ARBITER_DBLBUF_EN.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pix_en,
  input  logic              i_blank,
  input  logic [CNT_W-1:0]  i_hcount,
  input  logic [CNT_W-1:0]  i_vcount,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W:0]   o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_pixel,
  input  logic              i_swap_req,
  output logic              o_swap_ack
);

  localparam logic [CNT_W-1:0]  H_LIM     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LIM     = CNT_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(H_ACTIVE * V_ACTIVE);

  logic  w_disp_slot;
  logic  w_disp_sel;
  logic  w_draw_sel;
  slot_e w_slot;

  logic  r_pix_p1;
  logic  r_pix_p2;
  logic  r_rd_p1;
  logic  r_rd_p2;

  assign w_disp_slot = i_pix_en & ~i_blank & (i_hcount < H_LIM) & (i_vcount < V_LIM);

  // A write waits for a free slot and is never taken while its previous ack is showing.
  always_comb begin
    w_slot = SLOT_IDLE;
    if (w_disp_slot) begin
      w_slot = SLOT_READ;
    end else if (i_wr_req && !o_wr_ack) begin
      w_slot = (i_wr_addr < PIX_TOTAL) ? SLOT_WRITE : SLOT_DROP;
    end
  end

`ifdef VRAM_ARBITER_DBLBUF_EN
  logic r_disp_buf;
  logic r_swap_pend;
  logic w_frame_start;
  logic w_swap_go;

  assign w_frame_start = i_pix_en & (i_hcount == '0) & (i_vcount == '0);
  assign w_swap_go     = w_frame_start & r_swap_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_buf  <= 1'b0;
      r_swap_pend <= 1'b0;
      o_swap_ack  <= 1'b0;
    end else begin
      o_swap_ack <= w_swap_go;
      if (w_swap_go) begin
        r_disp_buf  <= ~r_disp_buf;
        r_swap_pend <= 1'b0;
      end else if (i_swap_req) begin
        r_swap_pend <= 1'b1;
      end
    end
  end

  // The first read of the new frame already uses the freshly swapped buffer.
  assign w_disp_sel = r_disp_buf ^ w_swap_go;
  assign w_draw_sel = ~w_disp_sel;
`else
  logic w_unused_swap;

  assign w_unused_swap = i_swap_req;
  assign w_disp_sel    = 1'b0;
  assign w_draw_sel    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_swap_ack <= 1'b0;
    end else begin
      o_swap_ack <= 1'b0;
    end
  end
`endif

  // RAM control strobes, write data and the write handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_wr_ack    <= 1'b0;
      o_ram_wdata <= '0;
    end else begin
      o_ram_en <= (w_slot == SLOT_READ) || (w_slot == SLOT_WRITE);
      o_ram_we <= (w_slot == SLOT_WRITE);
      o_wr_ack <= (w_slot == SLOT_WRITE) || (w_slot == SLOT_DROP);
      if (w_slot == SLOT_WRITE) begin
        o_ram_wdata <= i_wr_data;
      end
    end
  end

  // Pixel pipeline: slot -> RAM read cycle -> data valid -> captured into o_pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_p1 <= 1'b0;
      r_pix_p2 <= 1'b0;
      r_rd_p1  <= 1'b0;
      r_rd_p2  <= 1'b0;
      o_pixel  <= '0;
    end else begin
      r_pix_p1 <= i_pix_en;
      r_rd_p1  <= w_disp_slot;
      r_pix_p2 <= r_pix_p1;
      r_rd_p2  <= r_rd_p1;
      if (r_pix_p2) begin
        o_pixel <= r_rd_p2 ? i_ram_rdata : '0;
      end
    end
  end

  vram_addr_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_slot     (w_slot),
    .i_disp_sel (w_disp_sel),
    .i_draw_sel (w_draw_sel),
    .i_hcount   (i_hcount),
    .i_vcount   (i_vcount),
    .i_wr_addr  (i_wr_addr),
    .o_ram_addr (o_ram_addr)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected RAM ops, pixels and swap acks queued at stimulus time.
module tb_vram_arbiter;

`ifdef VRAM_ARBITER_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam int H = 640;
  localparam int V = 480;

  typedef struct {
    int          due;
    logic        en;
    logic        we;
    logic        ack;
    logic [19:0] addr;
    logic [7:0]  data;
  } op_t;

  typedef struct {
    int         due;
    logic [7:0] val;
  } pix_t;

  logic        clk;
  logic        rst_n;
  logic        pix_en, blank, wr_req, swap_req;
  logic [9:0]  hcount, vcount;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, ram_en, ram_we, swap_ack;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, pixel;

  op_t  exp_q[$];
  pix_t pix_q[$];
  int   swp_q[$];
  op_t  m_op;
  pix_t m_px;
  int   cyc;
  int   n_checks;
  int   n_errors;
  bit   disp_b;
  bit   draw_b;

  vram_arbiter u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pix_en    (pix_en),
    .i_blank     (blank),
    .i_hcount    (hcount),
    .i_vcount    (vcount),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_ack    (wr_ack),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_pixel     (pixel),
    .i_swap_req  (swap_req),
    .o_swap_ack  (swap_ack)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9};
  endfunction

  // VRAM model: data valid one clock after a read strobe.
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= ram_f(ram_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      m_op = exp_q.pop_front();
      check("op_due", cyc, m_op.due);
      check("ram_en", 32'(ram_en), 32'(m_op.en));
      check("ram_we", 32'(ram_we), 32'(m_op.we));
      check("wr_ack", 32'(wr_ack), 32'(m_op.ack));
      if (m_op.en) check("ram_addr", 32'(ram_addr), 32'(m_op.addr));
      if (m_op.we) check("ram_wdata", 32'(ram_wdata), 32'(m_op.data));
    end else if (ram_en || wr_ack) begin
      check("unexp_op", {30'd0, ram_en, wr_ack}, 32'd0);
    end
    if (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      m_px = pix_q.pop_front();
      check("pix_due", cyc, m_px.due);
      check("pixel", 32'(pixel), 32'(m_px.val));
    end
    if (swp_q.size() > 0 && swp_q[0] <= cyc) begin
      check("swap_ack", 32'(swap_ack), 32'd1);
      void'(swp_q.pop_front());
    end else if (swap_ack) begin
      check("unexp_swap", 32'(swap_ack), 32'd0);
    end
  end

  task automatic drive(input logic pe, input logic bl, input int h, input int v, input logic wq,
                       input logic [18:0] wa, input logic [7:0] wd, input logic sw);
    pix_en = pe; blank = bl; hcount = 10'(h); vcount = 10'(v);
    wr_req = wq; wr_addr = wa; wr_data = wd; swap_req = sw;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic push_read(input int h, input int v);
    op_t  o;
    pix_t p;
    o.due = cyc + 1; o.en = 1'b1; o.we = 1'b0; o.ack = 1'b0;
    o.addr = {disp_b, 19'(v * H + h)}; o.data = '0;
    exp_q.push_back(o);
    p.due = cyc + 3; p.val = ram_f(o.addr);
    pix_q.push_back(p);
  endtask

  task automatic push_blank_pix();
    pix_t p;
    p.due = cyc + 3; p.val = '0;
    pix_q.push_back(p);
  endtask

  task automatic push_write(input int due, input logic [18:0] wa, input logic [7:0] wd);
    op_t o;
    o.due = due; o.en = (wa < 19'(H * V)); o.we = o.en; o.ack = 1'b1;
    o.addr = {draw_b, wa}; o.data = wd;
    exp_q.push_back(o);
  endtask

  // Requester: raise at cycle n, still held while ack shows, then released.
  task automatic do_write(input logic [18:0] wa, input logic [7:0] wd);
    push_write(cyc + 1, wa, wd);
    drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
    idle(2);
  endtask

  task automatic read_slot(input int h, input int v, input logic sw);
    push_read(h, v);
    drive(1'b1, 1'b0, h, v, 1'b0, '0, '0, sw);
    idle(3);
  endtask

  initial begin
    int h, v;
    logic [18:0] wa;
    logic [7:0]  wd;
    logic        bl;
    cyc = 0; n_checks = 0; n_errors = 0;
    disp_b = 1'b0; draw_b = DBL;
    rst_n = 1'b0; ram_rdata = '0;
    pix_en = 0; blank = 0; hcount = 0; vcount = 0;
    wr_req = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
    repeat (3) @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_swap_ack", 32'(swap_ack), 32'd0);
    rst_n = 1'b1;
    idle(2);

    read_slot(5, 2, 1'b0);
    idle(1);
    do_write(19'd100, 8'hAB);

    // Held request with a new word each ack: one write every two clocks.
    for (int k = 0; k < 4; k++) begin
      wa = 19'(300 + k); wd = 8'(8'h10 + k);
      push_write(cyc + 1, wa, wd);
      drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
      if (k < 3) drive(1'b0, 1'b0, 0, 0, 1'b1, 19'(301 + k), 8'(8'h11 + k), 1'b0);
      else       drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
    end
    idle(3);

    // Write arriving with a display slot: read first, write one clock later.
    push_read(10, 3);
    push_write(cyc + 2, 19'd200, 8'h3C);
    drive(1'b1, 1'b0, 10, 3, 1'b1, 19'd200, 8'h3C, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 19'd200, 8'h3C, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 19'd200, 8'h3C, 1'b0);
    idle(3);

    do_write(19'd307200, 8'h55);

    // Non-display pix_en slots blank the pixel.
    read_slot(639, 479, 1'b0);
    push_blank_pix(); drive(1'b1, 1'b1, 5, 2, 1'b0, '0, '0, 1'b0); idle(3);
    read_slot(320, 240, 1'b0);
    push_blank_pix(); drive(1'b1, 1'b0, 640, 10, 1'b0, '0, '0, 1'b0); idle(3);
    read_slot(1, 1, 1'b0);
    push_blank_pix(); drive(1'b1, 1'b0, 10, 480, 1'b0, '0, '0, 1'b0); idle(3);

    // Mixed traffic at the 1-in-4 pixel rate.
    for (int k = 0; k < 12; k++) begin
      h = int'($urandom_range(639, 1)); v = int'($urandom_range(479, 1));
      bl = ($urandom_range(3, 0) == 0);
      if (bl) push_blank_pix(); else push_read(h, v);
      drive(1'b1, bl, h, v, 1'b0, '0, '0, 1'b0);
      wa = ($urandom_range(4, 0) == 0) ? 19'(307200 + $urandom_range(999, 0))
                                       : 19'($urandom_range(307199, 0));
      wd = 8'($urandom_range(255, 0));
      push_write(cyc + 1, wa, wd);
      drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b1, wa, wd, 1'b0);
      idle(1);
    end
    idle(4);

    // Swap request mid-frame takes effect only at the next frame start.
    read_slot(3, 100, 1'b1);
    read_slot(7, 200, 1'b0);
    if (DBL) begin
      disp_b = ~disp_b; draw_b = ~draw_b;
      swp_q.push_back(cyc + 1);
    end
    push_read(0, 0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, '0, '0, 1'b0);
    check("swap_ack_frame", 32'(swap_ack), 32'(DBL));
    check("swap_buf_sel", 32'(ram_addr[19]), 32'(DBL));
    idle(3);
    do_write(19'd1234, 8'h5A);
    read_slot(1, 1, 1'b0);
    read_slot(0, 0, 1'b0);
    idle(4);

    // Reset in the middle of a write, request kept high through reset.
    pix_en = 0; wr_req = 1; wr_addr = 19'd500; wr_data = 8'h77;
    @(posedge clk); #1;
    check("mid_wr_en", {29'd0, ram_en, ram_we, wr_ack}, 32'd7);
    check("mid_wr_addr", 32'(ram_addr), 32'({draw_b, 19'd500}));
    rst_n = 1'b0; #1;
    check("rst_async_ctl", {28'd0, ram_en, ram_we, wr_ack, swap_ack}, 32'd0);
    check("rst_async_addr", 32'(ram_addr), 32'd0);
    check("rst_async_wdata", 32'(ram_wdata), 32'd0);
    check("rst_async_pixel", 32'(pixel), 32'd0);
    disp_b = 1'b0; draw_b = DBL;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_write(19'd500, 8'h77);
    read_slot(5, 2, 1'b0);
    idle(6);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("pix_q_empty", 32'(pix_q.size()), 32'd0);
    check("swp_q_empty", 32'(swp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/RAM data width.
REQ-002 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have port clk  in  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports pix_en, blank  in  1 each  pixel-slot strobe (1 clk in 4) and blanking, both from the sync generator.
REQ-007 SHALL have ports hcount, vcount  in  10 each  current pixel and line.
REQ-008 SHALL have ports wr_req  in  1, wr_addr  in  19, wr_data  in  DATA_W  drawing-side write request, linear address y*H_ACTIVE+x.
REQ-009 SHALL have port wr_ack  out  1  one-clk pulse: write accepted.
REQ-010 SHALL have ports ram_en, ram_we  out  1 each, ram_addr  out  20, ram_wdata  out  DATA_W  single-port VRAM control; ram_addr[19] = buffer select.
REQ-011 SHALL have port ram_rdata  in  DATA_W  VRAM read data, valid 1 clk after ram_en & ~ram_we.
REQ-012 SHALL have port pixel  out  DATA_W  pixel to the DAC.
REQ-013 SHALL have ports swap_req  in  1, swap_ack  out  1  frame-buffer swap handshake (used only with REQ-025).

Function
REQ-014 SHALL define display slot = pix_en & ~blank & hcount<H_ACTIVE & vcount<V_ACTIVE.
REQ-015 SHALL, in a display slot, register ram_en=1, ram_we=0, ram_addr={disp_buf, vcount*H_ACTIVE+hcount} for the next clk.
REQ-016 SHALL capture ram_rdata into pixel 2 clks after the ram_en read cycle (3 clks after the pix_en edge), holding it until the next capture.
REQ-017 SHALL force pixel to 0 at the capture point of any pix_en cycle that was not a display slot.
REQ-018 SHALL, when wr_req=1, no display slot, and wr_ack=0, register ram_en=1, ram_we=1, ram_addr={draw_buf, wr_addr}, ram_wdata=wr_data, and pulse wr_ack in that same registered cycle.
REQ-019 SHALL give the display slot priority on simultaneous wr_req; the write waits (requester holds wr_req/wr_addr/wr_data stable until wr_ack).
REQ-020 SHALL accept no write in a cycle where wr_ack=1 (max one write per 2 clks), preventing double acceptance.
REQ-021 SHALL drop writes with wr_addr >= H_ACTIVE*V_ACTIVE (ram_en stays 0) but still pulse wr_ack.
REQ-022 SHALL drive ram_en=0, ram_we=0 in any cycle with neither a read nor a write.

Reset
REQ-023 SHALL, on rst_n=0 at any time, asynchronously clear pixel, wr_ack, swap_ack, ram_en, ram_we, ram_addr, ram_wdata, disp_buf, pending-swap flag to 0; draw_buf = ~disp_buf = 1 (with REQ-025) else 0.
REQ-024 SHALL discard any in-flight read or write on reset; the first operation after release follows REQ-014..REQ-021.

Configuration
REQ-025 SHALL, with VRAM_ARBITER_DBLBUF_EN defined, latch swap_req into a pending flag, and at the frame boundary (pix_en & hcount==0 & vcount==0) toggle disp_buf and draw_buf together, clear pending, and pulse swap_ack one clk.
REQ-026 SHALL, without VRAM_ARBITER_DBLBUF_EN, tie disp_buf=draw_buf=0, ignore swap_req, hold swap_ack=0.

Structure
REQ-027 SHALL place H_ACTIVE/V_ACTIVE defaults, address width (19) and the display-slot/write-slot encoding in shared package vga_pkg.
REQ-028 SHALL implement the display address multiply in sub-module vram_addr_gen (y*H_ACTIVE+x, registered, shift-add for 640 = 512+128).

Verification
REQ-029 SHALL check: hcount=5, vcount=2, pix_en pulse, blank=0 -> ram_addr=1285, ram_we=0 next clk; pixel=ram_rdata 2 clks later.
REQ-030 SHALL check: wr_req=1, wr_addr=100, wr_data=0xAB on a non-pix_en clk -> ram_we=1, ram_addr=100, ram_wdata=0xAB, wr_ack=1 next clk, exactly once.
REQ-031 SHALL check: wr_req rising together with a display slot -> read issued first, write and wr_ack one clk later.
REQ-032 SHALL check: wr_addr=307200 -> wr_ack pulses, ram_en stays 0.
REQ-033 SHALL check (DBLBUF_EN): swap_req at vcount=100 -> swap_ack and ram_addr[19] flip only at next hcount=0,vcount=0; without macro swap_ack never asserts.
REQ-034 SHALL check: rst_n low mid-write -> all outputs 0 immediately; after release wr_req still high -> single fresh write and wr_ack.
